// File: rtl/pipeline_busy_buffer_pkg.sv
// Shared defaults and helpers for the pipeline busy buffer.
//   PBB_DATA_WIDTH_DEFAULT : default beat payload width
//   PBB_DEPTH_DEFAULT      : default FIFO depth
//   ptr_next()             : circular pointer increment that also works for
//                            non-power-of-2 depths
package pipeline_busy_buffer_pkg;

    localparam int unsigned PBB_DATA_WIDTH_DEFAULT = 32;
    localparam int unsigned PBB_DEPTH_DEFAULT      = 4;

    function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipeline_busy_buffer_if.sv
// Valid/busy handshake bundle around the pipeline busy buffer.
//   iPREV_VALID/iPREV_DATA/oPREV_BUSY : upstream side
//   oNEXT_VALID/oNEXT_DATA/iNEXT_BUSY : downstream side
//   oCOUNT                            : buffer occupancy
// The slave modport is the buffer; the master modport is its environment.
interface pipeline_busy_buffer_if
    import pipeline_busy_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PBB_DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = PBB_DEPTH_DEFAULT
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                  iPREV_VALID;
    logic                  oPREV_BUSY;
    logic [DATA_WIDTH-1:0] iPREV_DATA;
    logic                  oNEXT_VALID;
    logic                  iNEXT_BUSY;
    logic [DATA_WIDTH-1:0] oNEXT_DATA;
    logic [CNT_W-1:0]      oCOUNT;

    modport master (
        output iPREV_VALID, iPREV_DATA, iNEXT_BUSY,
        input  oPREV_BUSY, oNEXT_VALID, oNEXT_DATA, oCOUNT
    );

    modport slave (
        input  iPREV_VALID, iPREV_DATA, iNEXT_BUSY,
        output oPREV_BUSY, oNEXT_VALID, oNEXT_DATA, oCOUNT
    );

endinterface

// File: rtl/pipeline_buffer_mem.sv
// Simple-dual-port register array backing the busy buffer.
//   clk_i   : write clock
//   we_i    : write enable (one accepted push)
//   waddr_i : write slot
//   wdata_i : write payload
//   raddr_i : read slot (combinational read)
//   rdata_o : payload at raddr_i
// Contents are intentionally not reset; the owner tracks validity.
module pipeline_buffer_mem
    import pipeline_busy_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PBB_DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = PBB_DEPTH_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    input  logic [$clog2(DEPTH)-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0]      rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pipeline_busy_buffer.sv
// Receiving-side valid/busy pipeline buffer. Beats from upstream are stored
// in a DEPTH-entry circular FIFO; upstream backpressure comes from a register
// so there is no combinational path from downstream busy to upstream busy.
//   iCLOCK      : clock
//   inRESET     : asynchronous active-low reset
//   iRESET_SYNC : synchronous clear, drops any beat offered in that cycle
//   bus         : handshake bundle (slave side), see pipeline_busy_buffer_if
module pipeline_busy_buffer
    import pipeline_busy_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = PBB_DATA_WIDTH_DEFAULT,
    parameter int unsigned DEPTH      = PBB_DEPTH_DEFAULT
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iRESET_SYNC,
    pipeline_busy_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic                  push;
    logic                  pop;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  prev_busy_q, prev_busy_d;
    logic                  next_valid_q, next_valid_d;
    logic [DATA_WIDTH-1:0] rd_data;

    // Busy is only ever low while a slot is free, so push never overflows.
    // A beat offered during a sync clear is dropped, hence the gate here.
    assign push = bus.iPREV_VALID & ~prev_busy_q & ~iRESET_SYNC;
    assign pop  = next_valid_q & ~bus.iNEXT_BUSY;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) begin
            wr_ptr_d = PTR_W'(ptr_next(32'(wr_ptr_q), DEPTH));
        end
        if (pop) begin
            rd_ptr_d = PTR_W'(ptr_next(32'(rd_ptr_q), DEPTH));
        end
        prev_busy_d  = (count_d == CNT_W'(DEPTH));
        next_valid_d = (count_d != '0);
        if (iRESET_SYNC) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            prev_busy_d  = 1'b0;
            next_valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prev_busy_q  <= 1'b0;
            next_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prev_busy_q  <= prev_busy_d;
            next_valid_q <= next_valid_d;
        end
    end

    pipeline_buffer_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk_i   (iCLOCK),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.iPREV_DATA),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Storage is not reset, so mask the head while empty to present zero.
    assign bus.oPREV_BUSY  = prev_busy_q;
    assign bus.oNEXT_VALID = next_valid_q;
    assign bus.oNEXT_DATA  = next_valid_q ? rd_data : '0;
    assign bus.oCOUNT      = count_q;

endmodule

// File: tb/tb_pipeline_busy_buffer.sv
module tb_pipeline_busy_buffer;

    localparam int          DW    = 32;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic sync;

    always #5 clk = ~clk;

    pipeline_busy_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    pipeline_busy_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (sync),
        .bus         (bus.slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: a queue of stored beats plus the registered busy flag.
    logic [DW-1:0] mq[$];
    bit            m_busy = 1'b0;

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            nb;
        bit            eb;
        bit            ev;
        logic [DW-1:0] ed;
        int            ec;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},  64'(bus.oPREV_BUSY),  64'(m_busy));
        chk({tag, ".valid"}, 64'(bus.oNEXT_VALID), 64'(mq.size() != 0));
        chk({tag, ".data"},  64'(bus.oNEXT_DATA),  (mq.size() != 0) ? 64'(mq[0]) : 64'd0);
        chk({tag, ".count"}, 64'(bus.oCOUNT),      64'(mq.size()));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".busy"},  64'(bus.oPREV_BUSY),  64'd0);
        chk({tag, ".valid"}, 64'(bus.oNEXT_VALID), 64'd0);
        chk({tag, ".data"},  64'(bus.oNEXT_DATA),  64'd0);
        chk({tag, ".count"}, 64'(bus.oCOUNT),      64'd0);
    endtask

    // Called 1 time unit after a rising edge; applies inputs, checks the
    // current outputs against the model, then advances one clock.
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit nb, input bit s,
                         input string tag);
        bit push, pop;
        bus.iPREV_VALID = v;
        bus.iPREV_DATA  = d;
        bus.iNEXT_BUSY  = nb;
        sync            = s;
        check_model(tag);
        push = v && !m_busy && !s;
        pop  = (mq.size() != 0) && !nb;
        @(posedge clk);
        if (s) begin
            mq.delete();
            m_busy = 1'b0;
        end else begin
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(d);
            m_busy = (mq.size() == DEPTH);
        end
        #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0;
        mq.delete();
        m_busy = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("reset");
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        sync            = 1'b0;
        bus.iPREV_VALID = 1'b0;
        bus.iPREV_DATA  = '0;
        bus.iNEXT_BUSY  = 1'b0;

        tbl[0]  = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b1, 32'hA0, 1};
        tbl[1]  = '{1'b1, 32'hA1, 1'b1, 1'b0, 1'b1, 32'hA0, 2};
        tbl[2]  = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b1, 32'hA0, 3};
        tbl[3]  = '{1'b1, 32'hA3, 1'b1, 1'b1, 1'b1, 32'hA0, 4};
        tbl[4]  = '{1'b1, 32'hA4, 1'b1, 1'b1, 1'b1, 32'hA0, 4};
        tbl[5]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA1, 3};
        tbl[6]  = '{1'b1, 32'hA4, 1'b0, 1'b0, 1'b1, 32'hA2, 3};
        tbl[7]  = '{1'b1, 32'hA5, 1'b0, 1'b0, 1'b1, 32'hA3, 3};
        tbl[8]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hA4, 2};
        tbl[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hA5, 1};
        tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'h00, 0};

        // Reset and idle
        hard_reset();
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b0, "idle");

        // Streaming: first beat visible one cycle after its push, count stays 1
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b1, DW'(i), 1'b0, 1'b0, "stream");
            chk("stream.count1", 64'(bus.oCOUNT), 64'd1);
            chk("stream.head",   64'(bus.oNEXT_DATA), 64'(i));
        end
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b0, "stream_tail");

        // Fill to full, stall, then drain: hand-derived table
        for (int i = 0; i < 11; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].nb, 1'b0, "fill");
            chk($sformatf("tbl%0d.busy", i),  64'(bus.oPREV_BUSY),  64'(tbl[i].eb));
            chk($sformatf("tbl%0d.valid", i), 64'(bus.oNEXT_VALID), 64'(tbl[i].ev));
            chk($sformatf("tbl%0d.data", i),  64'(bus.oNEXT_DATA),  64'(tbl[i].ed));
            chk($sformatf("tbl%0d.count", i), 64'(bus.oCOUNT),      64'(tbl[i].ec));
        end

        // Simultaneous push/pop at count=2 with write pointer wrapping
        hard_reset();
        @(posedge clk); #1;
        cycle(1'b1, 32'hB0, 1'b1, 1'b0, "wrap_fill");
        cycle(1'b1, 32'hB1, 1'b1, 1'b0, "wrap_fill");
        cycle(1'b1, 32'hB2, 1'b1, 1'b0, "wrap_fill");
        cycle(1'b0, '0,     1'b0, 1'b0, "wrap_pop");
        chk("wrap.start_count", 64'(bus.oCOUNT), 64'd2);
        for (int i = 3; i < 9; i++) begin
            cycle(1'b1, DW'(32'hB0 + i), 1'b0, 1'b0, "wrap");
            chk("wrap.count2", 64'(bus.oCOUNT), 64'd2);
            chk("wrap.head",   64'(bus.oNEXT_DATA), 64'(32'hB0 + i - 1));
        end
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, "wrap_drain");

        // Synchronous clear at count=3 with a beat on offer
        cycle(1'b1, 32'hC0, 1'b1, 1'b0, "sync_fill");
        cycle(1'b1, 32'hC1, 1'b1, 1'b0, "sync_fill");
        cycle(1'b1, 32'hC2, 1'b1, 1'b0, "sync_fill");
        cycle(1'b1, 32'hC3, 1'b1, 1'b1, "sync_clr");
        chk("sync.count",  64'(bus.oCOUNT),      64'd0);
        chk("sync.valid",  64'(bus.oNEXT_VALID), 64'd0);
        repeat (3) begin
            cycle(1'b0, '0, 1'b0, 1'b0, "sync_after");
            chk("sync.nodrop_out", 64'(bus.oNEXT_VALID), 64'd0);
        end

        // Asynchronous reset between edges
        cycle(1'b1, 32'hD0, 1'b1, 1'b0, "async_fill");
        cycle(1'b1, 32'hD1, 1'b1, 1'b0, "async_fill");
        cycle(1'b1, 32'hD2, 1'b1, 1'b0, "async_fill");
        bus.iPREV_VALID = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_now");
        mq.delete();
        m_busy = 1'b0;
        @(posedge clk); #1;
        check_zero("async_hold");
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0, "async_after");

        // Random traffic against the queue model
        for (int i = 0; i < 10000; i++) begin
            bit v, nb, s;
            v  = ($urandom_range(0, 99) < 60);
            nb = ($urandom_range(0, 99) < 40);
            s  = ($urandom_range(0, 499) == 0);
            cycle(v, DW'($urandom), nb, s, "rand");
        end
        repeat (DEPTH + 2) cycle(1'b0, '0, 1'b0, 1'b0, "rand_drain");
        chk("final.empty", 64'(bus.oCOUNT), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
